// File: rtl/ldst_memory_port_pkg.sv
// Shared definitions for the load/store memory port: access-size encodings,
// outstanding-entry layout and the load alignment helpers.
package ldst_memory_port_pkg;

    typedef enum logic [1:0] {
        ORDER_BYTE = 2'd0,
        ORDER_HALF = 2'd1,
        ORDER_WORD = 2'd2
    } order_e;

    localparam int TAG_W   = 5;
    localparam int MASK_W  = 4;
    localparam int SHIFT_W = 2;

    // Outstanding entry layout: {RW, MASK, SHIFT, TAG}
    localparam int ENT_TAG_LSB   = 0;
    localparam int ENT_SHIFT_LSB = ENT_TAG_LSB + TAG_W;
    localparam int ENT_MASK_LSB  = ENT_SHIFT_LSB + SHIFT_W;
    localparam int ENT_RW_BIT    = ENT_MASK_LSB + MASK_W;
    localparam int ENT_W         = ENT_RW_BIT + 1;

    function automatic logic [31:0] lane_expand(input logic [MASK_W-1:0] mask);
        logic [31:0] lanes;
        lanes = '0;
        for (int i = 0; i < MASK_W; i++) begin
            lanes[8*i +: 8] = {8{mask[i]}};
        end
        return lanes;
    endfunction

    function automatic logic [31:0] align_load(input logic [31:0]        data,
                                               input logic [MASK_W-1:0]  mask,
                                               input logic [SHIFT_W-1:0] shift);
        return (data & lane_expand(mask)) >> {shift, 3'b000};
    endfunction

endpackage

// File: rtl/ldst_memory_port_if.sv
// Execute-request, data-memory and writeback signals of the load/store port.
// slave is the port itself; master is the surrounding execute/memory/writeback side.
interface ldst_memory_port_if;
    import ldst_memory_port_pkg::*;

    logic               iREQ_VALID;
    logic               oREQ_BUSY;
    logic               iREQ_RW;
    logic [31:0]        iREQ_PDT;
    logic [31:0]        iREQ_ADDR;
    logic [31:0]        iREQ_DATA;
    logic [1:0]         iREQ_ORDER;
    logic [MASK_W-1:0]  iREQ_MASK;
    logic [SHIFT_W-1:0] iREQ_SHIFT;
    logic [TAG_W-1:0]   iREQ_TAG;

    logic               oMEM_REQ;
    logic               iMEM_LOCK;
    logic               oMEM_RW;
    logic [31:0]        oMEM_PDT;
    logic [31:0]        oMEM_ADDR;
    logic [31:0]        oMEM_DATA;
    logic [MASK_W-1:0]  oMEM_MASK;
    logic               iMEM_VALID;
    logic [31:0]        iMEM_DATA;

    logic               oWB_VALID;
    logic [31:0]        oWB_DATA;
    logic [TAG_W-1:0]   oWB_TAG;
    logic               oALIGN_FAULT;
    logic               oPROTOCOL_ERR;

    modport slave (
        input  iREQ_VALID, iREQ_RW, iREQ_PDT, iREQ_ADDR, iREQ_DATA,
               iREQ_ORDER, iREQ_MASK, iREQ_SHIFT, iREQ_TAG,
               iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        output oREQ_BUSY,
               oMEM_REQ, oMEM_RW, oMEM_PDT, oMEM_ADDR, oMEM_DATA, oMEM_MASK,
               oWB_VALID, oWB_DATA, oWB_TAG, oALIGN_FAULT, oPROTOCOL_ERR
    );

    modport master (
        output iREQ_VALID, iREQ_RW, iREQ_PDT, iREQ_ADDR, iREQ_DATA,
               iREQ_ORDER, iREQ_MASK, iREQ_SHIFT, iREQ_TAG,
               iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        input  oREQ_BUSY,
               oMEM_REQ, oMEM_RW, oMEM_PDT, oMEM_ADDR, oMEM_DATA, oMEM_MASK,
               oWB_VALID, oWB_DATA, oWB_TAG, oALIGN_FAULT, oPROTOCOL_ERR
    );

endinterface

// File: rtl/ldst_outstanding_fifo.sv
// In-order tracker of issued memory accesses awaiting their response.
// Synchronous FIFO with occupancy count; push on full and pop on empty are ignored.
module ldst_outstanding_fifo #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2,
    parameter int P_WIDTH   = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic [P_WIDTH-1:0]   data_i,
    input  logic                 pop_i,
    output logic [P_WIDTH-1:0]   data_o,
    output logic [P_DEPTH_N:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int CW = P_DEPTH_N + 1;
    localparam logic [P_DEPTH_N:0] FULL_CNT = CW'(P_DEPTH);

    logic [P_WIDTH-1:0]   mem_q [P_DEPTH];
    logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_N:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + P_DEPTH_N'(do_push);
        rd_ptr_d = rd_ptr_q + P_DEPTH_N'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no control meaning, so it is left unreset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ldst_memory_port.sv
// Memory-side end of the execute load/store path: registers one request for
// the data bus, tracks outstanding accesses in order and aligns load returns.
module ldst_memory_port
    import ldst_memory_port_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iFLUSH,
    ldst_memory_port_if.slave bus
);

    localparam int CW = P_DEPTH_N + 1;
    localparam logic [P_DEPTH_N:0] DEPTH_CNT = CW'(P_DEPTH);

    // Issue stage
    logic               iss_vld_q,   iss_vld_d;
    logic               iss_rw_q,    iss_rw_d;
    logic [31:0]        iss_pdt_q,   iss_pdt_d;
    logic [31:2]        iss_addr_q,  iss_addr_d;
    logic [31:0]        iss_data_q,  iss_data_d;
    logic [MASK_W-1:0]  iss_mask_q,  iss_mask_d;
    logic [SHIFT_W-1:0] iss_shift_q, iss_shift_d;
    logic [TAG_W-1:0]   iss_tag_q,   iss_tag_d;

    // Response / status
    logic [P_DEPTH_N:0] disc_q,    disc_d;
    logic               wb_vld_q,  wb_vld_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [TAG_W-1:0]   wb_tag_q,  wb_tag_d;
    logic               fault_q,   fault_d;
    logic               perr_q,    perr_d;

    logic [ENT_W-1:0]   fifo_head;
    logic [ENT_W-1:0]   fifo_push_ent;
    logic [P_DEPTH_N:0] fifo_cnt;
    logic               fifo_full, fifo_empty;

    logic               iss_hs, rsp_pop, accept, mask_ok, req_busy;
    logic [P_DEPTH_N:0] occupancy, cnt_after;
    logic               head_rw;
    logic [MASK_W-1:0]  head_mask;
    logic [SHIFT_W-1:0] head_shift;
    logic [TAG_W-1:0]   head_tag;
    logic               unused_ok;

    assign iss_hs    = iss_vld_q && !bus.iMEM_LOCK;
    assign rsp_pop   = bus.iMEM_VALID && !fifo_empty;
    assign occupancy = fifo_cnt + CW'(iss_vld_q);
    // Busy looks at the registered count: a pop this cycle frees a slot only next cycle.
    assign req_busy  = (iss_vld_q && bus.iMEM_LOCK) || (occupancy == DEPTH_CNT) || iFLUSH;
    assign accept    = bus.iREQ_VALID && !req_busy;
    assign mask_ok   = |bus.iREQ_MASK;
    assign cnt_after = fifo_cnt + CW'(iss_hs) - CW'(rsp_pop);

    assign fifo_push_ent = {iss_rw_q, iss_mask_q, iss_shift_q, iss_tag_q};
    assign head_rw    = fifo_head[ENT_RW_BIT];
    assign head_mask  = fifo_head[ENT_MASK_LSB +: MASK_W];
    assign head_shift = fifo_head[ENT_SHIFT_LSB +: SHIFT_W];
    assign head_tag   = fifo_head[ENT_TAG_LSB +: TAG_W];

    // ORDER is implied by MASK/SHIFT; the byte offset only selects lanes.
    assign unused_ok = ^{bus.iREQ_ORDER, bus.iREQ_ADDR[1:0], fifo_full};

    ldst_outstanding_fifo #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N),
        .P_WIDTH   (ENT_W)
    ) u_fifo (
        .clk_i   (iCLOCK),
        .rst_ni  (inRESET),
        .clr_i   (1'b0),
        .push_i  (iss_hs),
        .data_i  (fifo_push_ent),
        .pop_i   (rsp_pop),
        .data_o  (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        iss_vld_d   = iss_vld_q;
        iss_rw_d    = iss_rw_q;
        iss_pdt_d   = iss_pdt_q;
        iss_addr_d  = iss_addr_q;
        iss_data_d  = iss_data_q;
        iss_mask_d  = iss_mask_q;
        iss_shift_d = iss_shift_q;
        iss_tag_d   = iss_tag_q;

        // A handshaking entry has already been pushed, so flush may drop the stage.
        if (iss_hs || iFLUSH) begin
            iss_vld_d = 1'b0;
        end
        if (accept && mask_ok) begin
            iss_vld_d   = 1'b1;
            iss_rw_d    = bus.iREQ_RW;
            iss_pdt_d   = bus.iREQ_PDT;
            iss_addr_d  = bus.iREQ_ADDR[31:2];
            iss_data_d  = bus.iREQ_DATA;
            iss_mask_d  = bus.iREQ_MASK;
            iss_shift_d = bus.iREQ_SHIFT;
            iss_tag_d   = bus.iREQ_TAG;
        end
    end

    always_comb begin
        fault_d   = accept && !mask_ok;
        perr_d    = perr_q || (bus.iMEM_VALID && fifo_empty);
        wb_vld_d  = 1'b0;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        disc_d    = disc_q;

        if (rsp_pop && !iFLUSH && (disc_q == '0) && !head_rw) begin
            wb_vld_d  = 1'b1;
            wb_data_d = align_load(bus.iMEM_DATA, head_mask, head_shift);
            wb_tag_d  = head_tag;
        end

        // Everything still in flight after a flush belongs to squashed instructions.
        if (iFLUSH) begin
            disc_d = cnt_after;
        end else if (rsp_pop && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            iss_vld_q   <= 1'b0;
            iss_rw_q    <= 1'b0;
            iss_pdt_q   <= '0;
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
            iss_mask_q  <= '0;
            iss_shift_q <= '0;
            iss_tag_q   <= '0;
            disc_q      <= '0;
            wb_vld_q    <= 1'b0;
            wb_data_q   <= '0;
            wb_tag_q    <= '0;
            fault_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            iss_vld_q   <= iss_vld_d;
            iss_rw_q    <= iss_rw_d;
            iss_pdt_q   <= iss_pdt_d;
            iss_addr_q  <= iss_addr_d;
            iss_data_q  <= iss_data_d;
            iss_mask_q  <= iss_mask_d;
            iss_shift_q <= iss_shift_d;
            iss_tag_q   <= iss_tag_d;
            disc_q      <= disc_d;
            wb_vld_q    <= wb_vld_d;
            wb_data_q   <= wb_data_d;
            wb_tag_q    <= wb_tag_d;
            fault_q     <= fault_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.oREQ_BUSY     = req_busy;
    assign bus.oMEM_REQ      = iss_vld_q;
    assign bus.oMEM_RW       = iss_rw_q;
    assign bus.oMEM_PDT      = iss_pdt_q;
    assign bus.oMEM_ADDR     = {iss_addr_q, 2'b00};
    assign bus.oMEM_DATA     = iss_data_q;
    assign bus.oMEM_MASK     = iss_mask_q;
    assign bus.oWB_VALID     = wb_vld_q;
    assign bus.oWB_DATA      = wb_data_q;
    assign bus.oWB_TAG       = wb_tag_q;
    assign bus.oALIGN_FAULT  = fault_q;
    assign bus.oPROTOCOL_ERR = perr_q;

endmodule
